sr_pulse_driver: RTL
====================

SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 Parameter N, default 4, number of driven SR channels (2..8).
REQ-002 Parameter PULSE_W, default 2, cycles an S or R line is held high (1..15).
REQ-003 Parameter GAP_W, default 1, idle cycles after a pulse before the next request is accepted (0..15).
REQ-004 clk  input  1  single clock, all state on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_ch  input  3  target channel index.
REQ-009 req_op  input  2  00 hold, 01 set, 10 reset, 11 illegal.
REQ-010 s  output  N  set lines to the SR flip-flop bank, one per channel.
REQ-011 r  output  N  reset lines to the SR flip-flop bank, one per channel.
REQ-012 shadow_q  output  N  tracked state of each driven flip-flop.
REQ-013 busy  output  1  pulse or gap in progress.
REQ-014 err_illegal  output  1  sticky error flag.
REQ-015 err_clr  input  1  synchronous clear of err_illegal.

Function
REQ-016 The FSM shall have exactly three states: IDLE, PULSE and GAP.
REQ-017 The block shall assert req_ready only in IDLE with rst_n high; a request is accepted on the posedge where req_valid and req_ready are both high.
REQ-018 The block shall assert busy exactly when state is not IDLE.
REQ-019 An accepted set whose req_ch < N and shadow_q[req_ch]=0 shall enter PULSE and drive s[req_ch]=1 for exactly PULSE_W cycles, starting on the cycle after acceptance.
REQ-020 An accepted reset whose req_ch < N and shadow_q[req_ch]=1 shall do the same on r[req_ch].
REQ-021 The shadow_q[ch] update shall occur on the posedge that ends the last PULSE cycle: to 1 for set, 0 for reset.
REQ-022 After PULSE the block shall spend GAP_W cycles in GAP with all s/r low; with GAP_W=0 it shall return directly to IDLE.
REQ-023 A redundant request (set with shadow 1, reset with shadow 0) and a hold (op 00) shall be accepted with no pulse, with the FSM staying in IDLE and req_ready staying high.
REQ-024 Op 11, or req_ch >= N, shall be accepted, shall set err_illegal on the next edge, and shall produce no pulse or shadow change.
REQ-025 An illegal request and err_clr in the same cycle shall leave err_illegal at 1 (set wins).
REQ-026 At most one bit of (s | r) shall be high in any cycle, and s[i] & r[i] shall never both be 1.
REQ-027 s, r, shadow_q and busy shall be registered outputs with no combinational path from req_* inputs.
REQ-028 req_valid while req_ready=0 shall be ignored with no side effects.

Reset
REQ-029 While rst_n=0 the block shall force s=0, r=0, shadow_q=0, busy=0, err_illegal=0, req_ready=0 and state=IDLE, independent of clk.
REQ-030 Reset asserted mid-PULSE shall drop the active s/r line immediately and leave shadow_q at 0; no partial update shall occur.
REQ-031 req_ready shall be 1 in the first cycle after rst_n deasserts.

Verification
REQ-032 N=4, PULSE_W=2, GAP_W=1; set on ch 2 accepted at edge k -> s=0100 during cycles k+1 and k+2, shadow_q=0100 after edge k+3, req_ready low for k+1..k+3, high at k+4.
REQ-033 After the set on ch 2, reset on ch 2 -> r=0100 for 2 cycles and shadow_q returns to 0000; s is never high in the same cycle.
REQ-034 Set on ch 1 while shadow_q[1]=1 -> no pulse, busy stays 0, req_ready stays 1; the next request is accepted on the following edge.
REQ-035 req_op=11, then separately req_ch=5 -> err_illegal=1 with s/r/shadow unchanged; err_clr with a concurrent illegal request -> still 1; err_clr alone -> 0 on the next edge.
REQ-036 rst_n pulled low asynchronously in the first PULSE cycle of a set on ch 0 -> s=0000 immediately, shadow_q=0000; after release, req_ready=1 on the first clock.
REQ-037 Random back-to-back requests for 10k cycles -> a checker confirms REQ-026 every cycle and that shadow_q matches a reference model.

Source files
------------

// File: rtl/sr_pulse_driver_if.sv
// ============================================================================
// Module   : sr_pulse_driver_if
// Brief    : Request handshake bundle for the SR pulse driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sr_pulse_driver_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_ch;
    logic [1:0] req_op;

    modport master (
        output req_valid,
        output req_ch,
        output req_op,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_ch,
        input  req_op,
        output req_ready
    );
endinterface

`default_nettype wire

// File: rtl/sr_pulse_driver.sv
// ============================================================================
// Module   : sr_pulse_driver
// Brief    : Drives timed S/R pulses into an SR flip-flop bank and shadows it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_pulse_driver #(
    parameter int N       = 4,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    sr_pulse_driver_if.slave   req,
    output logic [N-1:0]       s,
    output logic [N-1:0]       r,
    output logic [N-1:0]       shadow_q,
    output logic               busy,
    output logic               err_illegal,
    input  wire logic          err_clr
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_pulse = 2'd1;
    localparam logic [1:0] c_st_gap   = 2'd2;

    localparam logic [3:0] c_pulse_last = 4'(PULSE_W - 1);
    localparam logic [3:0] c_gap_last   = 4'(GAP_W - 1);
    localparam logic [3:0] c_num_ch     = 4'(N);

    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [2:0]   ch_q, ch_d;
    logic         set_q, set_d;
    logic [N-1:0] s_q, s_d;
    logic [N-1:0] r_q, r_d;
    logic [N-1:0] shadow_d;
    logic         err_q, err_d;

    logic         w_accept;
    logic         w_illegal;
    logic         w_cur_bit;
    logic [N-1:0] w_req_sel;
    logic [N-1:0] w_act_sel;

    function automatic logic [N-1:0] onehot(input logic [2:0] ch);
        logic [N-1:0] o;
        o = '0;
        for (int i = 0; i < N; i++) begin
            o[i] = (ch == 3'(i));
        end
        return o;
    endfunction

    // A decode rather than an index keeps out-of-range channels harmless.
    assign w_req_sel = onehot(req.req_ch);
    assign w_act_sel = onehot(ch_q);
    assign w_cur_bit = |(shadow_q & w_req_sel);
    assign w_illegal = (req.req_op == 2'b11) || ({1'b0, req.req_ch} >= c_num_ch);
    assign w_accept  = req.req_valid && req.req_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= c_st_idle;
            cnt_q    <= '0;
            ch_q     <= '0;
            set_q    <= 1'b0;
            s_q      <= '0;
            r_q      <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            set_q    <= set_d;
            s_q      <= s_d;
            r_q      <= r_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        set_d    = set_q;
        shadow_d = shadow_q;
        err_d    = err_q;

        // An illegal request overrides a concurrent clear.
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            c_st_idle: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        err_d = 1'b1;
                    end else if ((req.req_op == 2'b01) && !w_cur_bit) begin
                        state_d = c_st_pulse;
                        cnt_d   = c_pulse_last;
                        ch_d    = req.req_ch;
                        set_d   = 1'b1;
                    end else if ((req.req_op == 2'b10) && w_cur_bit) begin
                        state_d = c_st_pulse;
                        cnt_d   = c_pulse_last;
                        ch_d    = req.req_ch;
                        set_d   = 1'b0;
                    end
                end
            end
            c_st_pulse: begin
                if (cnt_q == 4'd0) begin
                    shadow_d = set_q ? (shadow_q | w_act_sel) : (shadow_q & ~w_act_sel);
                    if (GAP_W == 0) begin
                        state_d = c_st_idle;
                    end else begin
                        state_d = c_st_gap;
                        cnt_d   = c_gap_last;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            c_st_gap: begin
                if (cnt_q == 4'd0) begin
                    state_d = c_st_idle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Output logic: pulse lines are registered from the next state.
    always_comb begin
        s_d = '0;
        r_d = '0;
        if (state_d == c_st_pulse) begin
            if (set_d) begin
                s_d = onehot(ch_d);
            end else begin
                r_d = onehot(ch_d);
            end
        end
    end

    assign req.req_ready = rst_n && (state_q == c_st_idle);
    assign busy          = (state_q != c_st_idle);
    assign s             = s_q;
    assign r             = r_q;
    assign err_illegal   = err_q;

endmodule

`default_nettype wire
